button_events: RTL and testbench
================================

BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter BUTTONS, default 3: number of raw button inputs (1..15).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 12000: consecutive cycles a new level must hold (1 ms at 12 MHz).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, power of two, >=2.
REQ-004 SHALL have parameters REPEAT_DELAY, default 6000000, and REPEAT_PERIOD, default 1200000: auto-repeat timing in cycles.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port btn_n, input, BUTTONS: raw asynchronous buttons, active-low.
REQ-008 SHALL have port level, output, BUTTONS: debounced state, 1 = pressed.
REQ-009 SHALL have port evt_valid, output, 1: FIFO non-empty.
REQ-010 SHALL have port evt_data, output, 8: head event; [7] 1 = press / 0 = release, [6] repeat flag, [5:4] 0, [3:0] button index.
REQ-011 SHALL have port rd, input, 1: pop request from the CPU side.
REQ-012 SHALL have port overflow, output, 1: sticky, set when an event is dropped.
REQ-013 SHALL have port ovf_clr, input, 1: clears overflow.

Function
REQ-014 SHALL pass each btn_n bit through a 2-flop synchronizer, then invert it to get sync[i], where 1 = pressed.
REQ-015 SHALL keep one counter per button, cleared every cycle that sync[i] == level[i].
- While sync[i] != level[i], the counter increments.
REQ-016 On the cycle the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, SHALL:
- toggle level[i];
- clear the counter;
- set pending[i] with the new direction.
REQ-017 SHALL end any glitch shorter than DEBOUNCE_CYCLES with level and pending unchanged.
REQ-018 SHALL push at most one pending event per cycle, lowest index first; other pending bits wait and do not block debouncing.
REQ-019 A pending bit that is set again before being pushed SHALL overwrite the stored direction; the superseded event is dropped and overflow is set.
REQ-020 FIFO SHALL be first-word-fall-through: evt_data is valid whenever evt_valid=1; evt_data is don't-care when empty.
REQ-021 rd with evt_valid=1 SHALL pop the head, with the next entry visible the following cycle; rd when empty SHALL be ignored.
REQ-022 Push when full without a same-cycle pop SHALL drop the event, clear its pending bit and set overflow.
- Push and pop in the same cycle when full SHALL both succeed.
REQ-023 If ovf_clr and a new drop occur in the same cycle, overflow SHALL remain 1.
REQ-024 Latency: sync[i] mismatch start to evt_valid=1 SHALL be DEBOUNCE_CYCLES+1 cycles, with empty FIFO and no competing pending bits.
REQ-025 Pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter is clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 With rst=1 at a posedge, the block SHALL set:
- synchronizer flops to 1 (released);
- level, counters, pending, FIFO pointers and occupancy, overflow and repeat timers to 0.
REQ-027 Reset during a debounce or repeat interval SHALL abandon it with no event generated.
REQ-028 evt_valid SHALL be 0 on the first cycle after reset.

Configuration
REQ-029 Macro BUTTON_EVENTS_AUTOREPEAT_EN: when defined, while level[i]=1 a repeat event ([7]=1, [6]=1) SHALL be generated:
- first one REPEAT_DELAY cycles after the press event;
- then every REPEAT_PERIOD cycles;
- queued via the same pending/arbitration path.
Release SHALL stop repeats immediately.
REQ-030 When the macro is undefined, there SHALL be no repeat timers, REPEAT_* SHALL be ignored, and evt_data[6] SHALL always be 0.

Verification (DEBOUNCE_CYCLES=8, FIFO_DEPTH=4 unless stated)
REQ-031 btn_n[1] 1->0 held 20 cycles -> level[1]=1, evt_valid after 9 cycles, evt_data=8'h81; rd -> evt_valid=0.
REQ-032 btn_n[0] low-glitch of 7 cycles -> no event, level[0] stays 0.
REQ-033 btn_n[0] and btn_n[2] fall in the same cycle -> FIFO order 8'h80 then 8'h82, one cycle apart.
REQ-034 Six presses/releases without rd -> 4 entries kept in order, overflow=1; ovf_clr -> overflow=0.
REQ-035 FIFO full, rd and a new event in the same cycle -> event accepted, overflow stays 0.
REQ-036 With BUTTON_EVENTS_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10, btn 0 held -> 8'h80, then 8'hC0 at +20 and +30; release -> 8'h00, no further repeats.

Source files
------------

// File: rtl/button_events.sv
`default_nettype none
// =============================================================================
// Module   : button_events
// Purpose  : Debounces active-low buttons and queues press/release events in a
//            first-word-fall-through FIFO. Define BUTTON_EVENTS_AUTOREPEAT_EN
//            to add auto-repeat events while a button is held.
// Revision : 1.0 - initial release
// =============================================================================
module button_events #(
   parameter int BUTTONS         = 3,
   parameter int DEBOUNCE_CYCLES = 12000,
   parameter int FIFO_DEPTH      = 4,
   parameter int REPEAT_DELAY    = 6000000,
   parameter int REPEAT_PERIOD   = 1200000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [BUTTONS-1:0] btn_n,
   output logic [BUTTONS-1:0] level,
   output logic               evt_valid,
   output logic [7:0]         evt_data,
   input  logic               rd,
   output logic               overflow,
   input  logic               ovf_clr
);

   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int            AW       = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   logic [BUTTONS-1:0] sync1_q, sync2_q, sync;
   logic [BUTTONS-1:0] level_q, level_d;
   logic [CW-1:0]      cnt_q [BUTTONS];
   logic [CW-1:0]      cnt_d [BUTTONS];
   logic [BUTTONS-1:0] pend_q, pend_d, pdir_q, pdir_d;
   logic [BUTTONS-1:0] gnt;
   logic [3:0]         gnt_idx;
   logic               push, pop, full, accept, drop;
   logic [7:0]         push_data;
   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [AW-1:0]      wptr_q, rptr_q;
   logic [AW:0]        count_q, count_d;
   logic               overflow_q, overflow_d;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
   localparam int            RMAX         = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            RW           = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0]      rtmr_q [BUTTONS];
   logic [RW-1:0]      rtmr_d [BUTTONS];
   logic [BUTTONS-1:0] rfirst_q, rfirst_d;
   logic [BUTTONS-1:0] prep_q, prep_d;
`endif

   always_comb begin
      logic set, set_dir;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
      logic set_rep;
`endif
      sync = ~sync2_q;

      // Descending scan so the lowest pending index wins.
      gnt     = '0;
      gnt_idx = '0;
      for (int i = BUTTONS - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = 4'(i);
         end
      end

      push      = |pend_q;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
      push_data = {|(pdir_q & gnt), |(prep_q & gnt), 2'b00, gnt_idx};
`else
      push_data = {|(pdir_q & gnt), 1'b0, 2'b00, gnt_idx};
`endif
      pop    = rd && (count_q != '0);
      full   = (count_q == FULL_CNT);
      accept = push && (!full || pop);
      drop   = push && !accept;

      level_d = level_q;
      pend_d  = pend_q;
      pdir_d  = pdir_q;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
      prep_d   = prep_q;
      rfirst_d = rfirst_q;
`endif
      for (int i = 0; i < BUTTONS; i++) begin
         set     = 1'b0;
         set_dir = 1'b0;
         if (sync[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]   = '0;
            level_d[i] = ~level_q[i];
            set        = 1'b1;
            set_dir    = ~level_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
         // A level toggle (press or release) restarts the timer and outranks a repeat.
         set_rep   = 1'b0;
         rtmr_d[i] = rtmr_q[i] + RW'(1);
         if (!level_q[i] || set) begin
            rtmr_d[i]   = '0;
            rfirst_d[i] = 1'b1;
         end else if (rtmr_q[i] == (rfirst_q[i] ? RPT_DLY_LAST : RPT_PER_LAST)) begin
            rtmr_d[i]   = '0;
            rfirst_d[i] = 1'b0;
            set         = 1'b1;
            set_dir     = 1'b1;
            set_rep     = 1'b1;
         end
`endif

         if (set) begin
            if (pend_q[i] && !gnt[i]) drop = 1'b1;
            pend_d[i] = 1'b1;
            pdir_d[i] = set_dir;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
            prep_d[i] = set_rep;
`endif
         end else if (gnt[i]) begin
            pend_d[i] = 1'b0;
         end
      end

      count_d = count_q;
      if (accept && !pop)      count_d = count_q + (AW+1)'(1);
      else if (!accept && pop) count_d = count_q - (AW+1)'(1);

      overflow_d = (overflow_q && !ovf_clr) || drop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '1;
         sync2_q    <= '1;
         level_q    <= '0;
         pend_q     <= '0;
         pdir_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= '0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
         prep_q   <= '0;
         rfirst_q <= '0;
         for (int i = 0; i < BUTTONS; i++) rtmr_q[i] <= '0;
`endif
      end else begin
         sync1_q    <= btn_n;
         sync2_q    <= sync1_q;
         level_q    <= level_d;
         pend_q     <= pend_d;
         pdir_q     <= pdir_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < BUTTONS; i++) cnt_q[i] <= cnt_d[i];
         if (accept) wptr_q <= wptr_q + AW'(1);
         if (pop)    rptr_q <= rptr_q + AW'(1);
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
         prep_q   <= prep_d;
         rfirst_q <= rfirst_d;
         for (int i = 0; i < BUTTONS; i++) rtmr_q[i] <= rtmr_d[i];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[wptr_q] <= push_data;
   end

   assign level     = level_q;
   assign overflow  = overflow_q;
   assign evt_valid = (count_q != '0);
   assign evt_data  = mem_q[rptr_q];

endmodule
`default_nettype wire

// File: tb/tb_button_events.sv
`default_nettype none
// =============================================================================
// Module   : tb_button_events
// Purpose  : Directed stimulus for button_events, checked every cycle against a
//            queue-based behavioural model plus hand-computed literal checks.
// Revision : 1.0 - initial release
// =============================================================================
module tb_button_events;
   localparam int NB    = 3;
   localparam int DEB   = 8;
   localparam int DEPTH = 4;
   localparam int RDLY  = 20;
   localparam int RPER  = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NB-1:0] btn_n = '1;
   logic          rd = 1'b0;
   logic          ovf_clr = 1'b0;
   logic [NB-1:0] level;
   logic          evt_valid;
   logic [7:0]    evt_data;
   logic          overflow;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit started  = 1'b0;

   always #5 clk = ~clk;

   button_events #(
      .BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH),
      .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER)
   ) dut (
      .clk(clk), .rst(rst), .btn_n(btn_n), .level(level), .evt_valid(evt_valid),
      .evt_data(evt_data), .rd(rd), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: sync delay line, mismatch run lengths, pending slots and a queue.
   logic [NB-1:0] m_s1, m_s2, m_lvl, m_pend;
   int            m_run   [NB];
   int            m_since [NB];
   logic [7:0]    m_pev   [NB];
   logic [7:0]    m_q [$];
   logic          m_ovf;

   always @(posedge clk) begin
      int            g;
      bit            pop, drop, full, set, old;
      logic [7:0]    pdata, ev;
      logic [NB-1:0] sync;
      cyc++;
      if (rst) begin
         m_s1 = '1; m_s2 = '1; m_lvl = '0; m_pend = '0; m_ovf = 1'b0;
         m_q.delete();
         for (int i = 0; i < NB; i++) begin m_run[i] = 0; m_since[i] = 0; m_pev[i] = 8'h00; end
         started = 1'b1;
      end else begin
         sync  = ~m_s2;
         pop   = rd && (m_q.size() > 0);
         full  = (m_q.size() == DEPTH);
         drop  = 1'b0;
         pdata = 8'h00;
         g     = -1;
         for (int i = 0; i < NB; i++) if (m_pend[i] && g < 0) g = i;
         if (g >= 0) pdata = m_pev[g];
         for (int i = 0; i < NB; i++) begin
            set = 1'b0; ev = 8'h00; old = m_lvl[i];
            if (sync[i] != m_lvl[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin
                  m_run[i] = 0; m_lvl[i] = ~m_lvl[i]; set = 1'b1;
                  ev = {m_lvl[i], 3'b000, 4'(i)}; m_since[i] = 0;
               end
            end else m_run[i] = 0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
            if (!set && old) begin
               m_since[i]++;
               if (m_since[i] >= RDLY && (m_since[i] - RDLY) % RPER == 0) begin
                  set = 1'b1; ev = {2'b11, 2'b00, 4'(i)};
               end
            end
`endif
            if (set) begin
               if (m_pend[i] && g != i) drop = 1'b1;
               m_pend[i] = 1'b1; m_pev[i] = ev;
            end else if (g == i) m_pend[i] = 1'b0;
         end
         if (pop) void'(m_q.pop_front());
         if (g >= 0) begin
            if (!full || pop) m_q.push_back(pdata);
            else drop = 1'b1;
         end
         m_ovf = (m_ovf && !ovf_clr) || drop;
         m_s2 = m_s1; m_s1 = btn_n;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("level", level, m_lvl);
         check("evt_valid", evt_valid, m_q.size() > 0);
         if (evt_valid && m_q.size() > 0) check("evt_data", evt_data, m_q[0]);
         check("overflow", overflow, m_ovf);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_one();
      rd = 1'b1; tick(1); rd = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int waited);
      waited = 0;
      while (!evt_valid && waited < limit) begin tick(1); waited++; end
      check("wait_valid", evt_valid, 1);
   endtask

   task automatic toggle_btn1(input int times);
      for (int k = 0; k < times; k++) begin
         btn_n[1] = 1'b0; tick(12); btn_n[1] = 1'b1; tick(12);
      end
      tick(12);
   endtask

   initial begin
      int w, t0;
      logic [7:0] exp4 [4];
      rst = 1'b1; tick(2); rst = 1'b0;
      check("rst_level", level, 0);
      check("rst_valid", evt_valid, 0);
      check("rst_ovf", overflow, 0);
      tick(1);
      check("post_rst_valid", evt_valid, 0);

      // Single press: latency from raw edge = 2 sync + DEB + 1.
      btn_n[1] = 1'b0;
      wait_valid(30, w);
      check("press_latency", w, DEB + 3);
      check("press_data", evt_data, 8'h81);
      check("press_level", level[1], 1);
      pop_one();
      check("press_popped", evt_valid, 0);
      tick(8);
      btn_n[1] = 1'b1;
      wait_valid(30, w);
      check("release_data", evt_data, 8'h01);
      pop_one();

      // Glitch one cycle short of the debounce window.
      tick(2);
      btn_n[0] = 1'b0; tick(DEB - 1); btn_n[0] = 1'b1;
      tick(20);
      check("glitch_level", level[0], 0);
      check("glitch_valid", evt_valid, 0);

      // Simultaneous presses: lowest index first.
      btn_n[0] = 1'b0; btn_n[2] = 1'b0;
      wait_valid(30, w);
      check("simul_first", evt_data, 8'h80);
      pop_one();
      check("simul_second_valid", evt_valid, 1);
      check("simul_second", evt_data, 8'h82);
      pop_one();
      check("simul_empty", evt_valid, 0);
      btn_n[0] = 1'b1; btn_n[2] = 1'b1;
      wait_valid(30, w);
      check("simul_rel0", evt_data, 8'h00);
      pop_one();
      check("simul_rel2", evt_data, 8'h02);
      pop_one();

      // Six events into a four-deep FIFO.
      toggle_btn1(3);
      check("ovf_set", overflow, 1);
      exp4[0] = 8'h81; exp4[1] = 8'h01; exp4[2] = 8'h81; exp4[3] = 8'h01;
      for (int k = 0; k < 4; k++) begin
         check("ovf_keep_valid", evt_valid, 1);
         check("ovf_keep_data", evt_data, exp4[k]);
         pop_one();
      end
      check("ovf_drained", evt_valid, 0);
      ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
      check("ovf_cleared", overflow, 0);

      // Full FIFO: pop coincides with the push edge of a new press.
      toggle_btn1(2);
      check("full_no_ovf", overflow, 0);
      btn_n[1] = 1'b0;
      tick(DEB + 2);
      rd = 1'b1; tick(1); rd = 1'b0;
      check("fullpop_ovf", overflow, 0);
      exp4[0] = 8'h01; exp4[1] = 8'h81; exp4[2] = 8'h01; exp4[3] = 8'h81;
      for (int k = 0; k < 4; k++) begin
         check("fullpop_data", evt_data, exp4[k]);
         pop_one();
      end
      btn_n[1] = 1'b1;
      wait_valid(30, w);
      check("fullpop_rel", evt_data, 8'h01);
      pop_one();

      // Reset in the middle of a debounce interval abandons it.
      btn_n[2] = 1'b0; tick(6);
      rst = 1'b1; btn_n[2] = 1'b1; tick(1); rst = 1'b0;
      tick(20);
      check("rst_abandon_level", level[2], 0);
      check("rst_abandon_valid", evt_valid, 0);

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
      btn_n[0] = 1'b0;
      wait_valid(30, w);
      check("rpt_press", evt_data, 8'h80);
      t0 = cyc;
      pop_one();
      wait_valid(40, w);
      check("rpt1_time", cyc - t0, RDLY);
      check("rpt1_data", evt_data, 8'hC0);
      pop_one();
      tick(7);
      btn_n[0] = 1'b1;
      wait_valid(40, w);
      check("rpt2_time", cyc - t0, RDLY + RPER);
      check("rpt2_data", evt_data, 8'hC0);
      pop_one();
      wait_valid(40, w);
      check("rpt_release", evt_data, 8'h00);
      pop_one();
      tick(60);
      check("rpt_stopped", evt_valid, 0);
`else
      t0 = 0;
`endif

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
`default_nettype wire
